// File: rtl/branch_resolve_q.sv
// rtl/branch_resolve_q.sv - in-order branch prediction tracking queue with predictor update and redirect
// Optional feature: define BRU_STATS_EN to add saturating resolution/mispredict counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_resolve_q #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_rst,
    input  logic                    pred_push,
    input  logic                    pred_taken,
    input  logic [`ADDR_WIDTH-1:0]  pred_pc,
    output logic                    pred_full,
    input  logic                    branch_ex,
    input  logic                    is_loop_ex,
    input  logic                    branch_taken_ex,
    input  logic [`ADDR_WIDTH-1:0]  branch_pc_ex,
    input  logic [`ADDR_WIDTH-1:0]  branch_target_ex,
    input  logic                    flush,
    output logic                    upd_valid,
    output logic                    upd_taken,
    output logic [`ADDR_WIDTH-1:0]  upd_pc,
    output logic                    upd_is_loop,
    output logic                    mispredict,
    output logic [`ADDR_WIDTH-1:0]  redirect_pc,
`ifdef BRU_STATS_EN
    output logic [15:0]             stat_resolved,
    output logic [15:0]             stat_mispred,
`endif
    output logic                    proto_err
);

    localparam int AW = `ADDR_WIDTH;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic             mem_taken_q [DEPTH];
    logic [AW-1:0]    mem_pc_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             upd_valid_q, upd_taken_q, upd_is_loop_q;
    logic [AW-1:0]    upd_pc_q;
    logic             mispredict_q, mispredict_d;
    logic [AW-1:0]    redirect_pc_q, redirect_pc_d;
    logic             proto_err_q, proto_err_d;

    logic             full, empty;
    logic             push_ok, pop_ok, push_acc;
    logic             head_taken;
    logic             miss, clear;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Fullness is judged on the pre-pop occupancy, so a push at full is dropped even with a pop.
    assign push_ok    = pred_push && !full;
    assign pop_ok     = branch_ex && !empty;
    assign head_taken = empty ? 1'b0 : mem_taken_q[rd_ptr_q];
    assign miss       = branch_ex && (head_taken != branch_taken_ex);
    assign clear      = flush || miss;
    assign push_acc   = push_ok && !clear;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        mispredict_d  = 1'b0;
        redirect_pc_d = redirect_pc_q;
        proto_err_d   = proto_err_q;

        if (pred_push && full) begin
            proto_err_d = 1'b1;
        end
        if (branch_ex && empty) begin
            proto_err_d = 1'b1;
        end
        if (pop_ok && (mem_pc_q[rd_ptr_q] != branch_pc_ex)) begin
            proto_err_d = 1'b1;
        end

        if (clear) begin
            // Everything younger than a mispredicted branch is wrong-path.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_acc, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (miss && !flush) begin
            mispredict_d  = 1'b1;
            redirect_pc_d = branch_taken_ex ? branch_target_ex : (branch_pc_ex + AW'(4));
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_is_loop_q <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            upd_valid_q   <= branch_ex;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            proto_err_q   <= proto_err_d;
            if (branch_ex) begin
                upd_taken_q   <= branch_taken_ex;
                upd_pc_q      <= branch_pc_ex;
                upd_is_loop_q <= is_loop_ex;
            end
        end
    end

    // Entry payload carries no reset; occupancy alone decides validity.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst && push_acc) begin
            mem_taken_q[wr_ptr_q] <= pred_taken;
            mem_pc_q[wr_ptr_q]    <= pred_pc;
        end
    end

`ifdef BRU_STATS_EN
    logic [15:0] stat_resolved_q, stat_mispred_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (branch_ex && (stat_resolved_q != 16'hFFFF)) begin
                stat_resolved_q <= stat_resolved_q + 16'd1;
            end
            if (miss && (stat_mispred_q != 16'hFFFF)) begin
                stat_mispred_q <= stat_mispred_q + 16'd1;
            end
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

    assign pred_full   = full;
    assign upd_valid   = upd_valid_q;
    assign upd_taken   = upd_taken_q;
    assign upd_pc      = upd_pc_q;
    assign upd_is_loop = upd_is_loop_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_branch_resolve_q.sv
// tb/tb_branch_resolve_q.sv - self-checking bench for branch_resolve_q against a queue-based reference model
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_resolve_q;

    localparam int AW    = `ADDR_WIDTH;
    localparam int DEPTH = 4;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst;
    logic          pred_push, pred_taken;
    logic [AW-1:0] pred_pc;
    logic          pred_full;
    logic          branch_ex, is_loop_ex, branch_taken_ex;
    logic [AW-1:0] branch_pc_ex, branch_target_ex;
    logic          flush;
    logic          upd_valid, upd_taken, upd_is_loop;
    logic [AW-1:0] upd_pc;
    logic          mispredict;
    logic [AW-1:0] redirect_pc;
    logic          proto_err;
`ifdef BRU_STATS_EN
    logic [15:0]   stat_resolved, stat_mispred;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of outstanding predictions plus expected outputs.
    bit            m_taken [$];
    logic [AW-1:0] m_pc    [$];
    bit            m_proto;
    bit            e_mis;
    logic [AW-1:0] e_redir;
`ifdef BRU_STATS_EN
    int            m_res, m_mis;
`endif

    branch_resolve_q #(.DEPTH(DEPTH)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .pred_push(pred_push), .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_full(pred_full),
        .branch_ex(branch_ex), .is_loop_ex(is_loop_ex), .branch_taken_ex(branch_taken_ex),
        .branch_pc_ex(branch_pc_ex), .branch_target_ex(branch_target_ex), .flush(flush),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc), .upd_is_loop(upd_is_loop),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
`ifdef BRU_STATS_EN
        .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
        .proto_err(proto_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1;
        pred_push = 0; pred_taken = 0; pred_pc = '0;
        branch_ex = 0; is_loop_ex = 0; branch_taken_ex = 0;
        branch_pc_ex = '0; branch_target_ex = '0; flush = 0;
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        m_taken.delete(); m_pc.delete(); m_proto = 0;
`ifdef BRU_STATS_EN
        m_res = 0; m_mis = 0;
`endif
    endtask

    // One clock: predict from the model, drive, clock, then compare registered outputs.
    task automatic cyc(input bit push, input bit ptk, input logic [AW-1:0] ppc,
                       input bit bex, input bit loop, input bit btk,
                       input logic [AW-1:0] bpc, input logic [AW-1:0] btgt,
                       input bit fl, input bit verbose_chk);
        bit was_full, head_tk, miss;
        was_full = (m_taken.size() == DEPTH);
        if (push && was_full) m_proto = 1;
        head_tk = 0;
        if (bex) begin
            if (m_taken.size() == 0) m_proto = 1;
            else begin
                head_tk = m_taken[0];
                if (m_pc[0] != bpc) m_proto = 1;
            end
        end
        miss  = bex && (head_tk != btk);
        e_mis = miss && !fl;
        if (e_mis) e_redir = btk ? btgt : bpc + 4;
`ifdef BRU_STATS_EN
        if (bex && m_res < 16'hFFFF) m_res++;
        if (miss && m_mis < 16'hFFFF) m_mis++;
`endif
        if (fl || miss) begin
            m_taken.delete(); m_pc.delete();
        end else begin
            if (bex && m_taken.size() > 0) begin
                void'(m_taken.pop_front()); void'(m_pc.pop_front());
            end
            if (push && !was_full) begin
                m_taken.push_back(ptk); m_pc.push_back(ppc);
            end
        end

        pred_push = push; pred_taken = ptk; pred_pc = ppc;
        branch_ex = bex; is_loop_ex = loop; branch_taken_ex = btk;
        branch_pc_ex = bpc; branch_target_ex = btgt; flush = fl;
        @(posedge cpu_clk); #1;
        pred_push = 0; branch_ex = 0; flush = 0;

        if (verbose_chk) begin
            chk("upd_valid", upd_valid, bex);
            if (bex) begin
                chk("upd_taken", upd_taken, btk);
                chk("upd_pc", upd_pc, bpc);
                chk("upd_is_loop", upd_is_loop, loop);
            end
            chk("mispredict", mispredict, e_mis);
            if (e_mis) chk("redirect_pc", redirect_pc, e_redir);
            chk("pred_full", pred_full, m_taken.size() == DEPTH);
            chk("proto_err", proto_err, m_proto);
        end
    endtask

    initial begin
        logic [AW-1:0] r_pc, r_bpc;
        bit            r_push, r_bex, r_tk, r_fl;

        do_reset();
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_upd_taken", upd_taken, 0);
        chk("rst_upd_pc", upd_pc, 0);
        chk("rst_upd_is_loop", upd_is_loop, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_pred_full", pred_full, 0);

        // Two correct predictions retire in order.
        cyc(1, 1, 'h100, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 'h104, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 1, 'h100, 'h180, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 'h104, 'h1f0, 0, 1);
        chk("hit_no_proto", proto_err, 0);

        // Mispredicted not-taken redirects to target and discards the younger entry.
        cyc(1, 0, 'h200, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 'h204, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1, 'h200, 'h300, 0, 1);
        chk("miss_redirect_target", redirect_pc, 'h300);

        // Mispredicted taken redirects to the fall-through PC.
        cyc(1, 1, 'h400, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 'h400, 'h500, 0, 1);
        chk("miss_redirect_fallthru", redirect_pc, 'h404);

        // Fill, overflow, and push+pop around the full boundary.
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, AW'('h600 + 4*i), 0, 0, 0, 0, 0, 0, 1);
        chk("full_after_fill", pred_full, 1);
        cyc(1, 1, 'h700, 0, 0, 0, 0, 0, 0, 1);
        chk("overflow_proto", proto_err, 1);
        cyc(1, 1, 'h710, 1, 0, 1, 'h600, 'h800, 0, 1);
        cyc(1, 1, 'h714, 1, 0, 1, 'h604, 'h800, 0, 1);
        cyc(1, 1, 'h718, 0, 0, 0, 0, 0, 0, 1);

        // Resolution with an empty queue treats the prediction as not-taken.
        do_reset();
        cyc(0, 0, 0, 1, 0, 1, 'h900, 'ha00, 0, 1);
        chk("empty_pop_mis", mispredict, 1);
        chk("empty_pop_proto", proto_err, 1);

        // Flush drops everything without a redirect; a same-cycle resolution still updates.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, AW'('hb00 + 4*i), 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, AW'('hc00 + 4*i), 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 'hd00, 1, 1, 0, 'hc00, 'he00, 1, 1);
        chk("flush_no_mis", mispredict, 0);
        chk("flush_upd", upd_valid, 1);
        cyc(1, 1, 'hd04, 0, 0, 0, 0, 0, 0, 1);

        // Reset mid-operation overrides push and pop.
        cyc(1, 1, 'hd08, 0, 0, 0, 0, 0, 0, 1);
        pred_push = 1; branch_ex = 1; branch_taken_ex = 0; branch_pc_ex = 'hd04;
        do_reset();
        chk("midrst_upd_valid", upd_valid, 0);
        chk("midrst_mispredict", mispredict, 0);
        chk("midrst_full", pred_full, 0);
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, AW'('hf00 + 4*i), 0, 0, 0, 0, 0, 0, 1);

`ifdef BRU_STATS_EN
        do_reset();
        cyc(1, 1, 'h100, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 'h104, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1, 'h100, 'h200, 0, 1);
        cyc(0, 0, 0, 1, 0, 1, 'h104, 'h200, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 'h108, 'h200, 0, 1);
        chk("stat_resolved", stat_resolved, 3);
        chk("stat_mispred", stat_mispred, 1);
        for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 1, 0, 1, 'h10, 'h20, 0, 0);
        chk("stat_mispred_sat", stat_mispred, 16'hFFFF);
        chk("stat_resolved_sat", stat_resolved, 16'hFFFF);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r_push = ($urandom_range(0, 99) < 55);
            r_pc   = AW'($urandom) & ~AW'(3);
            r_bex  = ($urandom_range(0, 99) < 45);
            r_tk   = $urandom_range(0, 1);
            r_fl   = ($urandom_range(0, 99) < 4);
            if (m_pc.size() > 0 && $urandom_range(0, 15) != 0) r_bpc = m_pc[0];
            else r_bpc = AW'($urandom) & ~AW'(3);
            cyc(r_push, $urandom_range(0, 1), r_pc, r_bex, $urandom_range(0, 1), r_tk,
                r_bpc, AW'($urandom) & ~AW'(3), r_fl, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
